// File: rtl/adder_pkg.sv
// Shared definitions for the multi-cycle sliced adder/subtractor.
package adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic bit chunk_ok(input int unsigned width, input int unsigned chunk);
    return (chunk != 0) && (width >= chunk) && ((width % chunk) == 0);
  endfunction

endpackage

// File: rtl/adder_seq_if.sv
// Start/done handshake and operand/result bus for adder_seq.
interface adder_seq_if #(
  parameter int unsigned WIDTH = 16
) ();
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] s;
  logic             cout;
  logic             ovf;

  modport master (output start, a, b, cin, sub, input busy, done, s, cout, ovf);
  modport slave  (input start, a, b, cin, sub, output busy, done, s, cout, ovf);
endinterface

// File: rtl/adder_seq_add_chunk.sv
// Combinational CHUNK-bit ripple-carry adder slice.
module add_chunk #(
  parameter int unsigned CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout
);

  logic [CHUNK:0] c;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = cin;
    for (int unsigned i = 0; i < CHUNK; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
    end
    cout = c[CHUNK];
  end

endmodule

// File: rtl/adder_seq.sv
// Multi-cycle adder/subtractor: one CHUNK-bit slice per clock, start/done handshake,
// carry-out and signed-overflow flags.
module adder_seq
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input logic       clk,
  input logic       rst_n,
  adder_seq_if.slave bus
);

  localparam int unsigned N  = WIDTH / CHUNK;
  localparam int unsigned KW = (N > 1) ? $clog2(N) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(N - 1);

  if (!chunk_ok(WIDTH, CHUNK)) begin : g_bad_params
    $error("adder_seq: WIDTH must be a non-zero multiple of CHUNK");
  end

  state_e            state_q;
  logic [WIDTH-1:0]  a_q, b_q, res_q, s_q;
  logic              carry_q, a_msb_q, b_msb_q;
  logic              busy_q, done_q, cout_q, ovf_q;
  logic [KW-1:0]     k_q;

  logic [CHUNK-1:0]  sum_c;
  logic              carry_c;
  logic [WIDTH-1:0]  beff_c, a_d, b_d, res_d;

  add_chunk #(.CHUNK(CHUNK)) u_add_chunk (
    .a    (a_q[CHUNK-1:0]),
    .b    (b_q[CHUNK-1:0]),
    .cin  (carry_q),
    .s    (sum_c),
    .cout (carry_c)
  );

  // Operands shift right so the active slice is always at bit 0; sums enter at the top.
  always_comb begin
    logic [WIDTH+CHUNK-1:0] a_cat, b_cat, res_cat;
    beff_c  = bus.sub ? ~bus.b : bus.b;
    a_cat   = {CHUNK'(0), a_q};
    b_cat   = {CHUNK'(0), b_q};
    res_cat = {sum_c, res_q};
    a_d     = a_cat[WIDTH+CHUNK-1:CHUNK];
    b_d     = b_cat[WIDTH+CHUNK-1:CHUNK];
    res_d   = res_cat[WIDTH+CHUNK-1:CHUNK];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      s_q     <= '0;
      carry_q <= 1'b0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      k_q     <= '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            a_q     <= bus.a;
            b_q     <= beff_c;
            carry_q <= bus.cin;
            a_msb_q <= bus.a[WIDTH-1];
            b_msb_q <= beff_c[WIDTH-1];
            k_q     <= '0;
            busy_q  <= 1'b1;
            state_q <= ST_RUN;
          end else begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        ST_RUN: begin
          a_q     <= a_d;
          b_q     <= b_d;
          res_q   <= res_d;
          carry_q <= carry_c;
          k_q     <= k_q + KW'(1);
          // Results are registered on entry to DONE so they are visible with the done pulse.
          if (k_q == K_LAST) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            s_q     <= res_d;
            cout_q  <= carry_c;
            ovf_q   <= (a_msb_q == b_msb_q) && (res_d[WIDTH-1] != a_msb_q);
            state_q <= ST_DONE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.s    = s_q;
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;

endmodule
